cnn_mem_arbiter: RTL

CNN_MEM_ARBITER -- requirements
Module: cnn_mem_arbiter

---
 rtl/cnn_mem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cnn_mem_arbiter.sv
// Arbitrates one synchronous RAM between an external program loader and a CPU port.
// Defining CNN_MEM_ARB_PROTECT_EN blocks CPU writes below PROT_LIMIT and reports them on prot_err.
module cnn_mem_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 12,
  parameter int MEM_LAT    = 1,
  parameter int PROT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mode,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              prot_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, CPU_WAIT, CPU_DONE} state_t;

  localparam logic [2:0]      LAT      = 3'(MEM_LAT);
  localparam logic [ADDR_W:0] PROT_LIM = (ADDR_W+1)'(PROT_LIMIT);

`ifdef CNN_MEM_ARB_PROTECT_EN
  localparam bit PROT_ON = 1'b1;
  logic prot_err_q;
  assign prot_err = prot_err_q;
`else
  localparam bit PROT_ON = 1'b0;
  assign prot_err = 1'b0;
`endif

  state_t     state;
  logic [2:0] wait_cnt;
  logic       is_wr;
  logic       prot_hit;

  assign prot_hit = PROT_ON && cpu_we && ({1'b0, cpu_addr} < PROT_LIM);

  // NOTE: non-blocking assignments throughout, so every branch sees pre-edge register values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      is_wr     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      ld_ready  <= 1'b0;
      ld_count  <= '0;
`ifdef CNN_MEM_ARB_PROTECT_EN
      prot_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          // The loader wins a tie; the CPU request simply stays pending.
          if (load_mode) begin
            state    <= LOAD;
            ld_ready <= 1'b1;
            ld_count <= '0;
          end else if (cpu_req) begin
            state     <= CPU_WAIT;
            is_wr     <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_we    <= cpu_we && !prot_hit;
            wait_cnt  <= 3'd1;
          end
        end

        LOAD: begin
          mem_we <= ld_we;
          if (ld_we) begin
            mem_addr  <= ld_addr;
            mem_wdata <= ld_data;
            if (!ld_count[ADDR_W]) ld_count <= ld_count + 1'b1;
          end
          if (!load_mode) begin
            state    <= IDLE;
            ld_ready <= 1'b0;
          end
        end

        CPU_WAIT: begin
          mem_we <= 1'b0;
          if (wait_cnt == LAT) begin
            state     <= CPU_DONE;
            cpu_ready <= 1'b1;
            wait_cnt  <= '0;
            if (!is_wr) cpu_rdata <= mem_rdata;
`ifdef CNN_MEM_ARB_PROTECT_EN
            prot_err_q <= is_wr && ({1'b0, mem_addr} < PROT_LIM);
`endif
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        CPU_DONE: begin
          state     <= IDLE;
          cpu_ready <= 1'b0;
`ifdef CNN_MEM_ARB_PROTECT_EN
          prot_err_q <= 1'b0;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
